// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the multdiv unit (Booth multiplier and iterative
// divider): divider FSM state type, default widths, the most negative
// two's-complement operand, and exception codes common to both datapaths.
// No ports.
// ---------------------------------------------------------------------------
package multdiv_pkg;

  // Default operand width and iteration counter width (2^CNT_W > WIDTH).
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Most negative 32-bit operand; the only dividend that can overflow.
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Exception codes shared with the multiplier overflow check.
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_DIV_ZERO = 2'd1;
  localparam logic [1:0] EXC_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage : multdiv_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor; keeps the difference when it is non-negative.
// Ports:
//   i_r      partial remainder before the step (WIDTH+1 bits)
//   i_q_msb  dividend/quotient register msb shifted into the remainder
//   i_d      divisor magnitude (WIDTH bits)
//   o_r      partial remainder after the step
//   o_q_bit  quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic             o_q_bit
);

  // One guard bit beyond the remainder width so the borrow is the sign.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  assign w_shift = {i_r, i_q_msb};
  assign w_diff  = w_shift - {2'b00, i_d};

  // Restore (keep the shifted remainder) when the subtraction borrows.
  always_comb begin
    o_r     = w_shift[WIDTH:0];
    o_q_bit = 1'b0;
    if (w_diff[WIDTH+1] == 1'b0) begin
      o_r     = w_diff[WIDTH:0];
      o_q_bit = 1'b1;
    end else begin
      o_r     = w_shift[WIDTH:0];
      o_q_bit = 1'b0;
    end
  end

endmodule : div_step

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative signed divider: one quotient bit per cycle on operand
// magnitudes, then sign fix-up. Divide-by-zero and INT_MIN / -1 skip the
// iteration and report an exception with a zero result.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   ctrl_DIV        single-cycle start pulse; operands sampled on that edge,
//                   also aborts and restarts an op in progress
//   data_dividend   two's-complement dividend
//   data_divisor    two's-complement divisor
//   data_result     quotient truncated toward zero, held until next result
//   data_exception  exception flag, held with data_result
//   data_resultRDY  one-cycle pulse marking a valid result
//   busy            high while iterating or fixing the sign
// ---------------------------------------------------------------------------
module div_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_dividend,
  input  logic [WIDTH-1:0] data_divisor,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  // Magnitude of a two's-complement value; INT_MIN maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  div_state_t       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [1:0]       r_exc_code;

  logic [WIDTH:0]   w_r_next;
  logic             w_q_bit;
  logic [1:0]       w_exc_code;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r     (r_r),
    .i_q_msb (r_q[WIDTH-1]),
    .i_d     (r_d),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  // Classify the incoming operands before the iteration is committed.
  always_comb begin
    w_exc_code = EXC_NONE;
    if (data_divisor == W_ZERO) begin
      w_exc_code = EXC_DIV_ZERO;
    end else if ((data_dividend == W_MIN) && (data_divisor == W_ONES)) begin
      w_exc_code = EXC_OVERFLOW;
    end else begin
      w_exc_code = EXC_NONE;
    end
  end

  // Divider FSM with datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_q            <= W_ZERO;
      r_d            <= W_ZERO;
      r_r            <= {(WIDTH+1){1'b0}};
      r_cnt          <= {CNT_W{1'b0}};
      r_sign_a       <= 1'b0;
      r_sign_b       <= 1'b0;
      r_exc_code     <= EXC_NONE;
      data_result    <= W_ZERO;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        // A start in any state discards the op in flight.
        r_q        <= abs_val(data_dividend);
        r_d        <= abs_val(data_divisor);
        r_r        <= {(WIDTH+1){1'b0}};
        r_cnt      <= {CNT_W{1'b0}};
        r_sign_a   <= data_dividend[WIDTH-1];
        r_sign_b   <= data_divisor[WIDTH-1];
        r_exc_code <= w_exc_code;
        if (w_exc_code != EXC_NONE) begin
          r_state <= DONE;
          busy    <= 1'b0;
        end else begin
          r_state <= RUN;
          busy    <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          RUN: begin
            r_r   <= w_r_next;
            r_q   <= {r_q[WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == LAST_CNT) begin
              r_state <= FIX;
            end else begin
              r_state <= RUN;
            end
          end
          FIX: begin
            r_q     <= (r_sign_a ^ r_sign_b) ? -r_q : r_q;
            r_state <= DONE;
            busy    <= 1'b0;
          end
          DONE: begin
            data_result    <= (r_exc_code != EXC_NONE) ? W_ZERO : r_q;
            data_exception <= (r_exc_code != EXC_NONE);
            data_resultRDY <= 1'b1;
            r_state        <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : div_iter
